dmem_responder: RTL

//  Memory-side responder for the core's data-memory port: accepts one load/store

---
 rtl/dmem_responder.sv | 139 +++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store in flight at a time, LATENCY cycles from
// accept to a single-cycle response carrying read data or a write acknowledge.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_mask,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned WADR_W = 30;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY >= 2) ? LATENCY - 2 : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ready_q, ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;

  logic               we_q;
  logic [WADR_W-1:0]  waddr_q;
  logic [31:0]        wdata_q;
  logic [3:0]         mask_q;

  logic [31:0]        mem [DEPTH_WORDS];

  logic               accept_c;
  logic               enter_resp_c;
  logic               op_we_c;
  logic [WADR_W-1:0]  op_waddr_c;
  logic [31:0]        op_wdata_c;
  logic [3:0]         op_mask_c;
  logic               op_err_c;
  logic [IDX_W-1:0]   op_idx_c;
  logic               mem_we_c;
  logic               unused_addr_lsb;

  assign accept_c        = req_valid && ready_q;
  assign unused_addr_lsb = ^req_addr[1:0];

  // State and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          if (LATENCY <= 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // With LATENCY==1 the access happens on the accept edge, so take the live request
  always_comb begin
    op_we_c      = (state_q == S_IDLE) ? req_we          : we_q;
    op_waddr_c   = (state_q == S_IDLE) ? req_addr[31:2]  : waddr_q;
    op_wdata_c   = (state_q == S_IDLE) ? req_wdata       : wdata_q;
    op_mask_c    = (state_q == S_IDLE) ? req_mask        : mask_q;
    op_err_c     = op_waddr_c >= WADR_W'(DEPTH_WORDS);
    op_idx_c     = op_waddr_c[IDX_W-1:0];
    enter_resp_c = (state_d == S_RESP);

    ready_d     = (state_d == S_IDLE);
    rsp_valid_d = enter_resp_c;
    err_d       = enter_resp_c && op_err_c;
    rdata_d     = '0;
    if (enter_resp_c && !op_we_c && !op_err_c) rdata_d = mem[op_idx_c];
    mem_we_c    = enter_resp_c && op_we_c && !op_err_c;
  end

  always_ff @(posedge clk) begin
    if (accept_c) begin
      we_q    <= req_we;
      waddr_q <= req_addr[31:2];
      wdata_q <= req_wdata;
      mask_q  <= req_mask;
    end
  end

  // Array is never cleared; a reset edge suppresses the pending commit
  always_ff @(posedge clk) begin
    if (reset && mem_we_c) begin
      for (int i = 0; i < 4; i++) begin
        if (op_mask_c[i]) mem[op_idx_c][8*i +: 8] <= op_wdata_c[8*i +: 8];
      end
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
